// File: rtl/sdram_wb_frontend.sv
// Wishbone-classic slave front-end for the SDRAM controller user interface.
// Writes are posted through an in-order request FIFO; reads stall the bus until data returns.
module sdram_wb_frontend #(
    parameter int FIFO_AW  = 2,
    parameter int ADDR_LSB = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wb_cyc_i,
    input  logic               wb_stb_i,
    input  logic               wb_we_i,
    input  logic [31:0]        wb_adr_i,
    input  logic [31:0]        wb_dat_i,
    output logic [31:0]        wb_dat_o,
    output logic               wb_ack_o,
    output logic [22:0]        sdram_user_addr,
    output logic               sdram_rw,
    output logic [31:0]        sdram_data_in,
    output logic               sdram_in_valid,
    input  logic               sdram_busy,
    input  logic [31:0]        sdram_data_out,
    input  logic               sdram_out_valid,
    output logic [FIFO_AW:0]   fifo_count
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        ISS_IDLE   = 2'd0,
        ISS_GAP    = 2'd1,
        ISS_RDWAIT = 2'd2
    } iss_state_t;

    // Entry layout: {rw, word address, write data}
    logic [55:0]      fifo_mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr, rd_ptr;
    logic [55:0]      head;
    logic [22:0]      word_addr;
    logic             req, full, empty, push, pop, rd_ret;
    logic             rd_pending, rd_abandon, iss_rd_out;
    iss_state_t       state;
    logic             unused_adr;

    assign unused_adr = ^wb_adr_i;
    assign word_addr  = wb_adr_i[ADDR_LSB +: 23];
    assign fifo_count = wr_ptr - rd_ptr;
    assign full       = (fifo_count == FULL_CNT);
    assign empty      = (wr_ptr == rd_ptr);
    assign head       = fifo_mem[rd_ptr[FIFO_AW-1:0]];
    assign req        = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign pop        = (state == ISS_IDLE) & ~empty & ~sdram_busy;
    // A full FIFO still takes a push in the same cycle its head is popped
    assign push       = req & ~rd_pending & (~full | pop);
    assign rd_ret     = sdram_out_valid & iss_rd_out;

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr[FIFO_AW-1:0]] <= {wb_we_i, word_addr, wb_dat_i};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            wb_ack_o        <= 1'b0;
            wb_dat_o        <= '0;
            rd_pending      <= 1'b0;
            rd_abandon      <= 1'b0;
            iss_rd_out      <= 1'b0;
            sdram_in_valid  <= 1'b0;
            sdram_rw        <= 1'b0;
            sdram_user_addr <= '0;
            sdram_data_in   <= '0;
            state           <= ISS_IDLE;
        end else begin
            wb_ack_o       <= 1'b0;
            sdram_in_valid <= 1'b0;

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (wb_we_i)
                    wb_ack_o <= 1'b1;
                else
                    rd_pending <= 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;

            // Master gave up on the pending read: finish it silently
            if (rd_pending & ~wb_cyc_i)
                rd_abandon <= 1'b1;

            if (rd_ret) begin
                rd_pending <= 1'b0;
                rd_abandon <= 1'b0;
                iss_rd_out <= 1'b0;
                if (~rd_abandon & wb_cyc_i) begin
                    wb_dat_o <= sdram_data_out;
                    wb_ack_o <= 1'b1;
                end
            end

            case (state)
                ISS_IDLE: begin
                    if (pop) begin
                        sdram_in_valid  <= 1'b1;
                        sdram_rw        <= head[55];
                        sdram_user_addr <= head[54:32];
                        sdram_data_in   <= head[31:0];
                        iss_rd_out      <= ~head[55];
                        state           <= ISS_GAP;
                    end
                end
                ISS_GAP:    state <= iss_rd_out ? ISS_RDWAIT : ISS_IDLE;
                ISS_RDWAIT: if (~iss_rd_out) state <= ISS_IDLE;
                default:    state <= ISS_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_wb_frontend.sv
// Table-driven bench for sdram_wb_frontend with a behavioural SDRAM controller model.
module tb_sdram_wb_frontend;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
    logic [31:0] wb_adr_i = '0, wb_dat_i = '0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic [22:0] sdram_user_addr;
    logic        sdram_rw, sdram_in_valid;
    logic [31:0] sdram_data_in;
    logic        sdram_busy = 1'b0;
    logic [31:0] sdram_data_out = '0;
    logic        sdram_out_valid = 1'b0;
    logic [2:0]  fifo_count;

    sdram_wb_frontend #(.FIFO_AW(2), .ADDR_LSB(2)) dut (
        .clk(clk), .rst(rst),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
        .sdram_user_addr(sdram_user_addr), .sdram_rw(sdram_rw),
        .sdram_data_in(sdram_data_in), .sdram_in_valid(sdram_in_valid),
        .sdram_busy(sdram_busy), .sdram_data_out(sdram_data_out),
        .sdram_out_valid(sdram_out_valid), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [22:0] a;
        logic        rw;
        logic [31:0] d;
    } iss_t;

    iss_t exp_q[$];
    iss_t log_q[$];

    // Controller model: reads return 5 cycles after in_valid; writes update memory
    logic [31:0] mem [logic [22:0]];
    logic        spur = 1'b0;
    logic        prev_iv = 1'b0;
    logic        mem_init = 1'b0;
    logic [31:0] pend = '0;
    int          cnt = 0;
    int          consec_err = 0;
    int          ack_cnt = 0;

    always @(negedge clk) begin
        if (!mem_init) begin
            mem[23'h000800] = 32'h12345678;
            mem_init = 1'b1;
        end
        sdram_out_valid = 1'b0;
        if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
                sdram_out_valid = 1'b1;
                sdram_data_out  = pend;
            end
        end
        if (spur) begin
            sdram_out_valid = 1'b1;
            sdram_data_out  = 32'hBAD0BAD0;
        end
        if (sdram_in_valid) begin
            if (prev_iv) consec_err++;
            log_q.push_back('{sdram_user_addr, sdram_rw, sdram_data_in});
            if (sdram_rw)
                mem[sdram_user_addr] = sdram_data_in;
            else begin
                pend = mem.exists(sdram_user_addr) ? mem[sdram_user_addr] : 32'h0;
                cnt  = 5;
            end
        end
        prev_iv = sdram_in_valid;
        if (wb_ack_o) ack_cnt++;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One bus transaction; returns read data and cycles-to-ack (200 = timed out)
    task automatic txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       output logic [31:0] rdat, output int cycles);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr;  wb_dat_i = dat;
        cycles = 0;
        do begin
            @(posedge clk); #1;
            cycles++;
        end while (!wb_ack_o && cycles < 200);
        rdat = wb_dat_o;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [22:0] e_addr;
        logic [31:0] e_rdata;
        int          e_lat;
        int          gap;
    } vec_t;

    vec_t vt[8];

    initial begin
        logic [31:0] rd;
        logic [31:0] saved;
        int          c;
        int          a0;
        logic        got;

        vt[0] = '{1'b1, 32'h0000_1004, 32'hDEADBEEF, 23'h000401, 32'h0,        1, 10};
        vt[1] = '{1'b0, 32'h0000_2000, 32'h0,        23'h000800, 32'h12345678, 8, 10};
        vt[2] = '{1'b1, 32'h0000_0040, 32'hA5A5A5A5, 23'h000010, 32'h0,        1, 10};
        vt[3] = '{1'b0, 32'h0000_0040, 32'h0,        23'h000010, 32'hA5A5A5A5, 9, 0};
        vt[4] = '{1'b1, 32'hFFFF_FFFC, 32'h00000000, 23'h7FFFFF, 32'h0,        1, 10};
        vt[5] = '{1'b0, 32'hFFFF_FFFC, 32'h0,        23'h7FFFFF, 32'h00000000, 8, 10};
        vt[6] = '{1'b1, 32'h0000_0003, 32'h55AA55AA, 23'h000000, 32'h0,        1, 10};
        vt[7] = '{1'b0, 32'h0000_0000, 32'h0,        23'h000000, 32'h55AA55AA, 8, 10};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack",   64'(wb_ack_o), 64'(0));
        chk("rst_dat",   64'(wb_dat_o), 64'(0));
        chk("rst_iv",    64'(sdram_in_valid), 64'(0));
        chk("rst_addr",  64'(sdram_user_addr), 64'(0));
        chk("rst_cnt",   64'(fifo_count), 64'(0));
        rst = 1'b0;

        foreach (vt[i]) begin
            repeat (vt[i].gap) @(posedge clk);
            #0;
            if (vt[i].gap > 0) #1;
            txn(vt[i].we, vt[i].adr, vt[i].dat, rd, c);
            chk($sformatf("vec%0d_lat", i), 64'(c), 64'(vt[i].e_lat));
            if (!vt[i].we)
                chk($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vt[i].e_rdata));
            exp_q.push_back('{vt[i].e_addr, vt[i].we, vt[i].dat});
        end
        repeat (10) @(posedge clk);
        #1;

        // FIFO full: four posted writes fill it, the fifth waits for a pop
        sdram_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            txn(1'b1, 32'h400 + 32'(4 * i), 32'h1000 + 32'(i), rd, c);
            chk($sformatf("full_wr%0d_acked", i), 64'(c <= 2), 64'(1));
            exp_q.push_back('{23'h100 + 23'(i), 1'b1, 32'h1000 + 32'(i)});
        end
        chk("full_count", 64'(fifo_count), 64'(4));
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = 32'h410; wb_dat_i = 32'h1004;
        got = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (wb_ack_o) got = 1'b1;
        end
        chk("full_stall_ack", 64'(got), 64'(0));
        chk("full_stall_count", 64'(fifo_count), 64'(4));
        sdram_busy = 1'b0;
        @(posedge clk); #1;
        chk("full_push_pop_ack", 64'(wb_ack_o), 64'(1));
        chk("full_push_pop_count", 64'(fifo_count), 64'(4));
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        exp_q.push_back('{23'h104, 1'b1, 32'h1004});
        repeat (20) @(posedge clk);
        #1;
        chk("drain_count", 64'(fifo_count), 64'(0));

        // Spurious out_valid with nothing outstanding
        saved = wb_dat_o;
        a0 = ack_cnt;
        spur = 1'b1;
        @(posedge clk); #1;
        spur = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("spur_ack", 64'(ack_cnt), 64'(a0));
        chk("spur_dat", 64'(wb_dat_o), 64'(saved));

        // Reset while the read is outstanding in the controller
        a0 = ack_cnt;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h2000;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(posedge clk); #1;
            if (sdram_in_valid) got = 1'b1;
        end
        chk("rstrd_issued", 64'(got), 64'(1));
        exp_q.push_back('{23'h000800, 1'b0, 32'h0});
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rstrd_ack",   64'(wb_ack_o), 64'(0));
        chk("rstrd_dat",   64'(wb_dat_o), 64'(0));
        chk("rstrd_iv",    64'(sdram_in_valid), 64'(0));
        chk("rstrd_rw",    64'(sdram_rw), 64'(0));
        chk("rstrd_addr",  64'(sdram_user_addr), 64'(0));
        chk("rstrd_din",   64'(sdram_data_in), 64'(0));
        chk("rstrd_count", 64'(fifo_count), 64'(0));
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("rstrd_late_ack", 64'(ack_cnt), 64'(a0));
        txn(1'b1, 32'h80, 32'h77, rd, c);
        chk("post_rst_wr_lat", 64'(c), 64'(1));
        exp_q.push_back('{23'h000020, 1'b1, 32'h77});
        repeat (6) @(posedge clk);
        #1;

        chk("issue_count", 64'(log_q.size()), 64'(exp_q.size()));
        foreach (exp_q[i]) begin
            if (i < log_q.size()) begin
                chk($sformatf("issue%0d_addr", i), 64'(log_q[i].a), 64'(exp_q[i].a));
                chk($sformatf("issue%0d_rw", i), 64'(log_q[i].rw), 64'(exp_q[i].rw));
                if (exp_q[i].rw)
                    chk($sformatf("issue%0d_data", i), 64'(log_q[i].d), 64'(exp_q[i].d));
            end
        end
        chk("iv_back_to_back", 64'(consec_err), 64'(0));
        chk("total_acks", 64'(ack_cnt), 64'(14));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
